// File: rtl/data_bus_responder_pkg.sv
// ============================================================================
// Module   : data_bus_pkg
// Purpose  : Shared widths, response codes, fill word and write-FSM states
//            for the CPU data-bus responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package data_bus_pkg;

  localparam int ADDR_WIDTH_DEF     = 32;
  localparam int DATA_WIDTH_DEF     = 32;
  localparam int MEM_ADDR_WIDTH_DEF = 10;
  localparam int READ_LATENCY_DEF   = 2;
  localparam int RD_DEPTH_DEF       = 4;

  localparam logic [1:0]  RESP_OK   = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b10;
  localparam logic [31:0] FILL_WORD = 32'hDEAD_BEEF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RESP = 1'b1
  } wr_state_t;

endpackage : data_bus_pkg

`default_nettype wire

// File: rtl/data_bus_responder_if.sv
// ============================================================================
// Module   : data_bus_responder_if
// Purpose  : CPU data-bus read/write channels with CPU (master) and
//            responder (slave) views.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface data_bus_responder_if
  import data_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic                    dr_addr_valid;
  logic                    dr_addr_ready;
  logic [ADDR_WIDTH-1:0]   dr_addr;
  logic                    dr_data_valid;
  logic                    dr_data_ready;
  logic [DATA_WIDTH-1:0]   dr_data;

  logic                    dw_data_addr_valid;
  logic                    dw_data_addr_ready;
  logic [ADDR_WIDTH-1:0]   dw_addr;
  logic [DATA_WIDTH-1:0]   dw_data;
  logic [DATA_WIDTH/8-1:0] dw_strobe;
  logic                    dw_resp_valid;
  logic                    dw_resp_ready;
  logic [1:0]              dw_resp;

  modport master (
    output dr_addr_valid, dr_addr, dr_data_ready,
    output dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
    input  dr_addr_ready, dr_data_valid, dr_data,
    input  dw_data_addr_ready, dw_resp_valid, dw_resp
  );

  modport slave (
    input  dr_addr_valid, dr_addr, dr_data_ready,
    input  dw_data_addr_valid, dw_addr, dw_data, dw_strobe, dw_resp_ready,
    output dr_addr_ready, dr_data_valid, dr_data,
    output dw_data_addr_ready, dw_resp_valid, dw_resp
  );

endinterface : data_bus_responder_if

`default_nettype wire

// File: rtl/data_bus_responder_sync_fifo.sv
// ============================================================================
// Module   : sync_fifo
// Purpose  : Single-clock FIFO with same-cycle push+pop (legal even when full).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  wire logic                         clk,
  input  wire logic                         rst,
  input  wire logic                         i_push,
  input  wire logic [WIDTH-1:0]             i_data,
  input  wire logic                         i_pop,
  output logic      [WIDTH-1:0]             o_data,
  output logic                              o_full,
  output logic                              o_empty,
  output logic      [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int C_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int C_CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [C_PTR_W-1:0] r_wptr;
  logic [C_PTR_W-1:0] r_rptr;
  logic [C_CNT_W-1:0] r_count;
  logic               w_do_push;
  logic               w_do_pop;

  function automatic logic [C_PTR_W-1:0] f_inc(input logic [C_PTR_W-1:0] p);
    return (p == C_PTR_W'(DEPTH-1)) ? '0 : p + C_PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == C_CNT_W'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rptr];
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO may still take a push when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= f_inc(r_wptr);
      if (w_do_pop)  r_rptr <= f_inc(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + C_CNT_W'(1);
        2'b01:   r_count <= r_count - C_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule : sync_fifo

`default_nettype wire

// File: rtl/data_bus_responder.sv
// ============================================================================
// Module   : data_bus_responder
// Purpose  : Word-memory slave for the CPU data bus with configurable read
//            latency, bounded outstanding reads and a two-state write FSM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module data_bus_responder
  import data_bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MEM_ADDR_WIDTH = MEM_ADDR_WIDTH_DEF,
  parameter int READ_LATENCY   = READ_LATENCY_DEF,
  parameter int RD_DEPTH       = RD_DEPTH_DEF
) (
  input wire logic             clk,
  input wire logic             rst,
  data_bus_responder_if.slave  bus
);

  localparam int C_STRB_W    = DATA_WIDTH/8;
  localparam int C_MEM_DEPTH = 1 << MEM_ADDR_WIDTH;
  localparam int C_CNT_W     = $clog2(RD_DEPTH+1);

  logic [DATA_WIDTH-1:0]     r_mem [C_MEM_DEPTH];

  logic                      w_rd_fire;
  logic                      w_rd_pop;
  logic                      w_rd_in_range;
  logic [MEM_ADDR_WIDTH-1:0] w_rd_idx;
  logic [DATA_WIDTH-1:0]     w_rd_word;
  logic [READ_LATENCY-1:0]   r_pipe_vld;
  logic [DATA_WIDTH-1:0]     r_pipe_data [READ_LATENCY];
  logic [DATA_WIDTH-1:0]     w_fifo_data;
  logic                      w_fifo_full;
  logic                      w_fifo_empty;
  logic [C_CNT_W-1:0]        w_fifo_count;
  int                        w_outstanding;

  logic                      w_wr_fire;
  logic                      w_wr_in_range;
  logic [MEM_ADDR_WIDTH-1:0] w_wr_idx;
  wr_state_t                 r_wr_state;
  wr_state_t                 w_wr_state_nxt;
  logic [1:0]                r_resp;
  logic [1:0]                w_resp_nxt;
  logic                      w_dw_ready;
  logic                      w_resp_valid;
  logic                      w_unused;

  // ---------------------------------------------------------------- read path
  assign w_rd_fire     = bus.dr_addr_valid && bus.dr_addr_ready;
  assign w_rd_idx      = bus.dr_addr[MEM_ADDR_WIDTH+1:2];
  assign w_rd_in_range = (bus.dr_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] == '0);
  assign w_rd_word     = w_rd_in_range ? r_mem[w_rd_idx] : DATA_WIDTH'(FILL_WORD);

  always_comb begin
    w_outstanding = int'(w_fifo_count);
    for (int i = 0; i < READ_LATENCY; i++) begin
      if (r_pipe_vld[i]) w_outstanding = w_outstanding + 1;
    end
  end

  assign bus.dr_addr_ready = rst && (w_outstanding < RD_DEPTH);
  assign bus.dr_data_valid = rst && !w_fifo_empty;
  assign bus.dr_data       = bus.dr_data_valid ? w_fifo_data : '0;
  assign w_rd_pop          = bus.dr_data_valid && bus.dr_data_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_fire;
      for (int i = 1; i < READ_LATENCY; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  // Memory is sampled before this edge's write lands, so same-cycle reads see old data.
  always_ff @(posedge clk) begin
    r_pipe_data[0] <= w_rd_word;
    for (int i = 1; i < READ_LATENCY; i++) r_pipe_data[i] <= r_pipe_data[i-1];
  end

  sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RD_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (r_pipe_vld[READ_LATENCY-1]),
    .i_data  (r_pipe_data[READ_LATENCY-1]),
    .i_pop   (w_rd_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // --------------------------------------------------------------- write path
  assign w_wr_fire     = bus.dw_data_addr_valid && w_dw_ready;
  assign w_wr_idx      = bus.dw_addr[MEM_ADDR_WIDTH+1:2];
  assign w_wr_in_range = (bus.dw_addr[ADDR_WIDTH-1:MEM_ADDR_WIDTH+2] == '0);

  always_ff @(posedge clk) begin
    if (w_wr_fire && w_wr_in_range) begin
      for (int b = 0; b < C_STRB_W; b++) begin
        if (bus.dw_strobe[b]) r_mem[w_wr_idx][b*8 +: 8] <= bus.dw_data[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_state <= IDLE;
      r_resp     <= RESP_OK;
    end else begin
      r_wr_state <= w_wr_state_nxt;
      r_resp     <= w_resp_nxt;
    end
  end

  always_comb begin
    w_wr_state_nxt = r_wr_state;
    w_resp_nxt     = r_resp;
    w_dw_ready     = 1'b0;
    w_resp_valid   = 1'b0;
    case (r_wr_state)
      IDLE: begin
        w_dw_ready = rst;
        if (bus.dw_data_addr_valid && rst) begin
          w_wr_state_nxt = RESP;
          w_resp_nxt     = w_wr_in_range ? RESP_OK : RESP_ERR;
        end
      end
      RESP: begin
        w_resp_valid = rst;
        if (bus.dw_resp_ready) w_wr_state_nxt = IDLE;
      end
      default: w_wr_state_nxt = IDLE;
    endcase
  end

  assign bus.dw_data_addr_ready = w_dw_ready;
  assign bus.dw_resp_valid      = w_resp_valid;
  assign bus.dw_resp            = r_resp;

  // Byte-offset bits are ignored by word addressing; full is implied by the outstanding bound.
  assign w_unused = ^{bus.dr_addr[1:0], bus.dw_addr[1:0], w_fifo_full};

endmodule : data_bus_responder

`default_nettype wire

// File: tb/tb_data_bus_responder.sv
// ============================================================================
// Module   : tb_data_bus_responder
// Purpose  : Directed stimulus with queue scoreboard for data_bus_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_bus_responder;
  import data_bus_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  logic [31:0] rq[$];
  logic [1:0]  wq[$];

  always #5 clk = ~clk;

  data_bus_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  data_bus_responder #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .MEM_ADDR_WIDTH (10),
    .READ_LATENCY   (2),
    .RD_DEPTH       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: pops the oldest expectation whenever a response transfers.
  always @(negedge clk) begin
    if (rst === 1'b1 && bus.dr_data_valid && bus.dr_data_ready) begin
      if (rq.size() == 0) check("rd_unexpected", bus.dr_data, 32'hxxxx_xxxx);
      else check("rd_data", bus.dr_data, rq.pop_front());
    end
    if (rst === 1'b1 && bus.dw_resp_valid && bus.dw_resp_ready) begin
      if (wq.size() == 0) check("wr_unexpected", {30'd0, bus.dw_resp}, 32'hxxxx_xxxx);
      else check("wr_resp", {30'd0, bus.dw_resp}, {30'd0, wq.pop_front()});
    end
  end

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] er);
    int n = 0;
    wq.push_back(er);
    bus.dw_addr = a; bus.dw_data = d; bus.dw_strobe = s;
    bus.dw_data_addr_valid = 1'b1;
    @(negedge clk);
    while (!bus.dw_data_addr_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) begin
      check("wr_accept_timeout", 32'd0, 32'd1);
      void'(wq.pop_back());
    end
    @(posedge clk); #1;
    bus.dw_data_addr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp);
    int n = 0;
    rq.push_back(exp);
    bus.dr_addr = a;
    bus.dr_addr_valid = 1'b1;
    @(negedge clk);
    while (!bus.dr_addr_ready && n < 50) begin n++; @(negedge clk); end
    if (n >= 50) begin
      check("rd_accept_timeout", 32'd0, 32'd1);
      void'(rq.pop_back());
    end
    @(posedge clk); #1;
    bus.dr_addr_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((rq.size() != 0 || wq.size() != 0) && n < 100) begin
      n++; @(posedge clk); #1;
    end
    if (n >= 100) check("drain_timeout", 32'(rq.size() + wq.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    bus.dr_addr_valid = 1'b1; bus.dr_addr = '0; bus.dr_data_ready = 1'b1;
    bus.dw_data_addr_valid = 1'b1; bus.dw_addr = '0; bus.dw_data = '0;
    bus.dw_strobe = '0; bus.dw_resp_ready = 1'b1;

    // Reset with all valids high
    repeat (3) begin
      @(negedge clk);
      check("rst_dr_data_valid", {31'd0, bus.dr_data_valid}, 32'd0);
      check("rst_dw_resp_valid", {31'd0, bus.dw_resp_valid}, 32'd0);
      check("rst_dr_addr_ready", {31'd0, bus.dr_addr_ready}, 32'd0);
      check("rst_dw_addr_ready", {31'd0, bus.dw_data_addr_ready}, 32'd0);
    end
    check("rst_dr_data", bus.dr_data, 32'd0);
    @(posedge clk); #1;
    bus.dr_addr_valid = 1'b0; bus.dw_data_addr_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("idle_dr_addr_ready", {31'd0, bus.dr_addr_ready}, 32'd1);
    check("idle_dw_addr_ready", {31'd0, bus.dw_data_addr_ready}, 32'd1);
    @(posedge clk); #1;

    // Write then read with latency check
    do_write(32'h10, 32'hCAFE_F00D, 4'hF, RESP_OK);
    @(negedge clk);
    check("wr_resp_valid_next", {31'd0, bus.dw_resp_valid}, 32'd1);
    @(posedge clk); #1;
    do_read(32'h10, 32'hCAFE_F00D);
    @(negedge clk); check("rd_lat_c1", {31'd0, bus.dr_data_valid}, 32'd0);
    @(negedge clk); check("rd_lat_c2", {31'd0, bus.dr_data_valid}, 32'd0);
    @(negedge clk); check("rd_lat_c3", {31'd0, bus.dr_data_valid}, 32'd1);
    @(posedge clk); #1;
    wait_drain();

    // Byte strobes and misaligned addresses
    do_write(32'h20, 32'h1122_3344, 4'hF, RESP_OK);
    do_write(32'h22, 32'hAABB_CCDD, 4'b0101, RESP_OK);
    do_read(32'h23, 32'h11BB_33DD);
    wait_drain();

    // Back-pressure: only RD_DEPTH reads accepted while responses stall
    for (int i = 0; i < 6; i++) do_write(32'(i*4), 32'h0B0B_0000 + 32'(i), 4'hF, RESP_OK);
    wait_drain();
    bus.dr_data_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_read(32'(i*4), 32'h0B0B_0000 + 32'(i));
    bus.dr_addr = 32'h10; bus.dr_addr_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_addr_ready", {31'd0, bus.dr_addr_ready}, 32'd0);
      check("bp_head_hold", bus.dr_data, 32'h0B0B_0000);
    end
    @(posedge clk); #1;
    bus.dr_data_ready = 1'b1;
    do_read(32'h10, 32'h0B0B_0004);
    do_read(32'h14, 32'h0B0B_0005);
    wait_drain();

    // Out-of-range write/read and held write response
    bus.dw_resp_ready = 1'b0;
    do_write(32'h0000_1000, 32'h1234_5678, 4'hF, RESP_ERR);
    repeat (5) begin
      @(negedge clk);
      check("err_resp_hold", {31'd0, bus.dw_resp_valid}, 32'd1);
      check("err_addr_ready", {31'd0, bus.dw_data_addr_ready}, 32'd0);
    end
    @(posedge clk); #1;
    bus.dw_resp_ready = 1'b1;
    wait_drain();
    do_read(32'h0000_1000, 32'hDEAD_BEEF);
    do_read(32'h0, 32'h0B0B_0000);
    wait_drain();

    // Zero-strobe write is an OK no-op
    do_write(32'h4, 32'hFFFF_FFFF, 4'h0, RESP_OK);
    do_read(32'h4, 32'h0B0B_0001);
    wait_drain();

    // Same-cycle read sees old data, later read sees new data
    fork
      do_write(32'h8, 32'h7777_7777, 4'hF, RESP_OK);
      do_read(32'h8, 32'h0B0B_0002);
    join
    do_read(32'h8, 32'h7777_7777);
    wait_drain();

    // Reset while reads are in flight
    bus.dr_data_ready = 1'b0;
    for (int i = 0; i < 3; i++) do_read(32'(i*4), 32'h0B0B_0000 + 32'(i));
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    rq.delete();
    bus.dr_data_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("mid_rst_no_valid", {31'd0, bus.dr_data_valid}, 32'd0);
      check("mid_rst_addr_ready", {31'd0, bus.dr_addr_ready}, 32'd1);
    end
    @(posedge clk); #1;
    bus.dr_data_ready = 1'b0;
    for (int i = 0; i < 4; i++) do_read(32'h20 + 32'(i*4), (i == 0) ? 32'h11BB_33DD : 32'hDEAD_BEEF);
    @(negedge clk);
    check("post_rst_full", {31'd0, bus.dr_addr_ready}, 32'd0);
    @(posedge clk); #1;
    // Words 9..11 were never written: drop their expectations and just drain
    rq.delete();
    rq.push_back(32'h11BB_33DD);
    bus.dr_data_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.dr_data_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_first", 32'(rq.size()), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    bus.dr_data_ready = 1'b1;

    check("final_rq_empty", 32'(rq.size()), 32'd0);
    check("final_wq_empty", 32'(wq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_data_bus_responder

`default_nettype wire
